// File: rtl/shift_right_pipe.sv
// ---------------------------------------------------------------------------
// shift_right_pipe
//
// Three-stage pipelined 64-bit right barrel shifter for the LSR/ASR path.
// Supports logical (zero-fill) and arithmetic (sign-fill) shifts of 0-63 bits.
// Each stage resolves two bits of the shift amount with two cascaded 2:1 mux
// levels:
//   stage 1: shift[1:0] -> 0/1/2/3
//   stage 2: shift[3:2] -> 0/4/8/12
//   stage 3: shift[5:4] -> 0/16/32/48
// The fill bit (arith & dataIn[63]) is captured at acceptance and travels with
// the operation, so later stages never need the original operand.
//
// Stages advance independently, so an empty stage accepts from upstream even
// while downstream is stalled. Throughput is one operation per cycle.
//
// Ports:
//   clk          rising-edge clock for all state
//   reset        synchronous, active-high; clears all pipeline state
//   in_valid     upstream presents an operation
//   in_ready     block accepts the operation this cycle
//   dataIn       64-bit operand
//   shift        shift amount, 0-63
//   arith        1 = arithmetic (fill with dataIn[63]), 0 = logical (fill 0)
//   out_valid    shiftedData holds a result
//   out_ready    downstream consumes the result this cycle
//   shiftedData  result register (stage 3 data)
// ---------------------------------------------------------------------------
module shift_right_pipe (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] dataIn,
    input  logic [5:0]  shift,
    input  logic        arith,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] shiftedData
);

    // -----------------------------------------------------------------------
    // Pipeline state
    // -----------------------------------------------------------------------
    // Stage 1: partially shifted data, fill bit and the four unresolved
    // shift bits (shift[5:2]).
    logic        v1_q;
    logic [63:0] data1_q;
    logic        fill1_q;
    logic [3:0]  shamt1_q;

    // Stage 2: two unresolved shift bits remain (shift[5:4]).
    logic        v2_q;
    logic [63:0] data2_q;
    logic        fill2_q;
    logic [1:0]  shamt2_q;

    // Stage 3: final result; no shift bits or fill left to carry.
    logic        v3_q;
    logic [63:0] data3_q;

    // -----------------------------------------------------------------------
    // Stage advance control
    // -----------------------------------------------------------------------
    // A stage may load when it is empty or when its own contents move on
    // this cycle. The chain is a short AND/OR ripple from out_ready back to
    // in_ready, which is what lets a full pipeline accept and emit in the
    // same cycle.
    logic en1;
    logic en2;
    logic en3;

    always_comb begin
        en3      = !v3_q | out_ready;
        en2      = !v2_q | en3;
        en1      = !v1_q | en2;
        in_ready = en1 & !reset;
    end

    // -----------------------------------------------------------------------
    // Stage 1 shift network (bits 0 and 1 of the shift amount)
    // -----------------------------------------------------------------------
    logic        fill_in;
    logic [63:0] s1_l0;
    logic [63:0] s1_l1;

    always_comb begin
        fill_in = arith & dataIn[63];
        s1_l0   = shift[0] ? {fill_in, dataIn[63:1]}      : dataIn;
        s1_l1   = shift[1] ? {{2{fill_in}}, s1_l0[63:2]} : s1_l0;
    end

    // -----------------------------------------------------------------------
    // Stage 2 shift network (bits 2 and 3 of the shift amount)
    // -----------------------------------------------------------------------
    logic [63:0] s2_l0;
    logic [63:0] s2_l1;

    always_comb begin
        s2_l0 = shamt1_q[0] ? {{4{fill1_q}}, data1_q[63:4]} : data1_q;
        s2_l1 = shamt1_q[1] ? {{8{fill1_q}}, s2_l0[63:8]}   : s2_l0;
    end

    // -----------------------------------------------------------------------
    // Stage 3 shift network (bits 4 and 5 of the shift amount)
    // -----------------------------------------------------------------------
    logic [63:0] s3_l0;
    logic [63:0] s3_l1;

    always_comb begin
        s3_l0 = shamt2_q[0] ? {{16{fill2_q}}, data2_q[63:16]} : data2_q;
        s3_l1 = shamt2_q[1] ? {{32{fill2_q}}, s3_l0[63:32]}   : s3_l0;
    end

    // -----------------------------------------------------------------------
    // Stage 1 register
    // -----------------------------------------------------------------------
    // Data only loads alongside a valid operation so that bubbles never
    // disturb the payload registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q     <= 1'b0;
            data1_q  <= 64'h0;
            fill1_q  <= 1'b0;
            shamt1_q <= 4'h0;
        end else if (en1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                data1_q  <= s1_l1;
                fill1_q  <= fill_in;
                shamt1_q <= shift[5:2];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2 register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            v2_q     <= 1'b0;
            data2_q  <= 64'h0;
            fill2_q  <= 1'b0;
            shamt2_q <= 2'h0;
        end else if (en2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                data2_q  <= s2_l1;
                fill2_q  <= fill1_q;
                shamt2_q <= shamt1_q[3:2];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 3 register (output)
    // -----------------------------------------------------------------------
    // Holding data3_q when no new valid arrives keeps shiftedData stable
    // through an output stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            v3_q    <= 1'b0;
            data3_q <= 64'h0;
        end else if (en3) begin
            v3_q <= v2_q;
            if (v2_q) begin
                data3_q <= s3_l1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        out_valid   = v3_q;
        shiftedData = data3_q;
    end

endmodule

// File: tb/tb_shift_right_pipe.sv
module tb_shift_right_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] dataIn;
    logic [5:0]  shift;
    logic        arith;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] shiftedData;

    int          tests_run = 0;
    int          fails     = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    shift_right_pipe dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dataIn      (dataIn),
        .shift       (shift),
        .arith       (arith),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .shiftedData (shiftedData)
    );

    // Reference: plain SystemVerilog shift operators.
    function automatic logic [63:0] ref_shift(input logic [63:0] d, input logic [5:0] s,
                                              input logic a);
        logic signed [63:0] sd;
        sd = d;
        if (a) return sd >>> s;
        return d >> s;
    endfunction

    // One cycle: drive at the falling edge, sample 1ns later (before the next
    // rising edge), then wait for the rising edge that performs the transfers.
    task automatic tick(input logic iv, input logic [63:0] d, input logic [5:0] s,
                        input logic a, input logic ordy,
                        output logic acc, output logic ox, output logic ov,
                        output logic [63:0] od);
        @(negedge clk);
        in_valid  = iv;
        dataIn    = d;
        shift     = s;
        arith     = a;
        out_ready = ordy;
        #1;
        acc = iv & in_ready;
        ov  = out_valid;
        ox  = out_valid & ordy;
        od  = shiftedData;
        @(posedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dataIn    = '0;
        shift     = '0;
        arith     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        tests_run++;
        if (shiftedData !== 64'h0) begin
            fails++;
            $display("FAIL reset_data: got %h want 0", shiftedData);
        end
        tests_run++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_in_ready: got %b want 0 while reset high", in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_single();
        logic acc, ox, ov;
        logic [63:0] od;
        int lat;
        logic [63:0] e;
        tick(1'b1, 64'd455, 6'd6, 1'b0, 1'b1, acc, ox, ov, od);
        tests_run++;
        if (acc !== 1'b1) begin
            fails++;
            $display("FAIL single_accept: got %b want 1", acc);
        end
        exp_q.push_back(64'd7);
        lat = -1;
        for (int n = 1; n <= 8 && lat < 0; n++) begin
            tick(1'b0, 64'h0, 6'd0, 1'b0, 1'b1, acc, ox, ov, od);
            if (ox) begin
                lat = n;
                e = exp_q.pop_front();
                tests_run++;
                if (od !== e) begin
                    fails++;
                    $display("FAIL single_data: got %h want %h", od, e);
                end
            end
        end
        tests_run++;
        if (lat !== 3) begin
            fails++;
            $display("FAIL single_latency: got %0d want 3 (-1 = timeout)", lat);
        end
    endtask

    task automatic test_sign_fill();
        logic acc, ox, ov;
        logic [63:0] od;
        logic [63:0] e;
        logic [63:0] ops_d[3];
        logic [5:0]  ops_s[3];
        logic        ops_a[3];
        logic [63:0] ops_e[3];
        int sent, got;
        ops_d = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
        ops_s = '{6'd63, 6'd63, 6'd0};
        ops_a = '{1'b1, 1'b0, 1'b1};
        ops_e = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000};
        sent = 0;
        got  = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            if (sent < 3)
                tick(1'b1, ops_d[sent], ops_s[sent], ops_a[sent], 1'b1, acc, ox, ov, od);
            else
                tick(1'b0, 64'h0, 6'd0, 1'b0, 1'b1, acc, ox, ov, od);
            if (ox) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sign_unexpected: got %h with empty scoreboard", od);
                end else begin
                    e = exp_q.pop_front();
                    if (od !== e) begin
                        fails++;
                        $display("FAIL sign_fill_%0d: got %h want %h", got, od, e);
                    end
                end
                got++;
            end
            if (acc) begin
                exp_q.push_back(ops_e[sent]);
                sent++;
            end
        end
        tests_run++;
        if (got !== 3) begin
            fails++;
            $display("FAIL sign_count: got %0d want 3", got);
        end
    endtask

    task automatic test_stream();
        logic acc, ox, ov;
        logic [63:0] od;
        logic [63:0] e;
        logic [63:0] d;
        int sent, got, gaps, misses, bad;
        bit seen;
        d    = 64'hF0F0_F0F0_F0F0_F0F0;
        sent = 0;
        got  = 0;
        gaps = 0;
        misses = 0;
        bad  = 0;
        seen = 1'b0;
        for (int c = 0; c < 100 && got < 64; c++) begin
            tick(sent < 64, d, 6'(sent), sent[0], 1'b1, acc, ox, ov, od);
            if (sent < 64 && !acc) misses++;
            if (ox) begin
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL stream_unexpected: got %h with empty scoreboard", od);
                end else begin
                    e = exp_q.pop_front();
                    if (od !== e) begin
                        bad++;
                        $display("FAIL stream_data_%0d: got %h want %h", got, od, e);
                    end
                end
                got++;
            end else if (seen) begin
                gaps++;
            end
            if (acc) begin
                exp_q.push_back(ref_shift(d, 6'(sent), sent[0]));
                sent++;
            end
        end
        tests_run++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL stream_results: %0d wrong results, want 0", bad);
        end
        tests_run++;
        if (got !== 64) begin
            fails++;
            $display("FAIL stream_count: got %0d want 64", got);
        end
        tests_run++;
        if (gaps !== 0) begin
            fails++;
            $display("FAIL stream_gaps: got %0d output gaps want 0", gaps);
        end
        tests_run++;
        if (misses !== 0) begin
            fails++;
            $display("FAIL stream_accept: got %0d refused inputs want 0", misses);
        end
    endtask

    task automatic test_backpressure();
        logic acc, ox, ov;
        logic [63:0] od, held, e, d;
        logic [5:0] s;
        logic a;
        int accepts, unstable, got;
        bit have_held;
        accepts   = 0;
        unstable  = 0;
        got       = 0;
        have_held = 1'b0;
        held      = '0;
        for (int i = 0; i < 6; i++) begin
            d = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
            s = 6'($urandom_range(1, 63));
            a = i[0];
            tick(1'b1, d, s, a, 1'b0, acc, ox, ov, od);
            if (acc) begin
                accepts++;
                exp_q.push_back(ref_shift(d, s, a));
            end
            if (ov) begin
                if (!have_held) begin
                    held      = od;
                    have_held = 1'b1;
                end else if (od !== held) begin
                    unstable++;
                end
            end
        end
        tests_run++;
        if (accepts !== 3) begin
            fails++;
            $display("FAIL bp_accepts: got %0d want 3", accepts);
        end
        tests_run++;
        if (have_held !== 1'b1) begin
            fails++;
            $display("FAIL bp_out_valid: got %b want 1 during stall", have_held);
        end
        tests_run++;
        if (unstable !== 0) begin
            fails++;
            $display("FAIL bp_stable: got %0d changes of shiftedData want 0", unstable);
        end
        for (int c = 0; c < 10; c++) begin
            tick(1'b0, 64'h0, 6'd0, 1'b0, 1'b1, acc, ox, ov, od);
            if (ox) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL bp_duplicate: got %h with empty scoreboard", od);
                end else begin
                    e = exp_q.pop_front();
                    if (od !== e) begin
                        fails++;
                        $display("FAIL bp_drain_%0d: got %h want %h", got, od, e);
                    end
                end
                got++;
            end
        end
        tests_run++;
        if (got !== 3 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL bp_drain_count: got %0d drained, %0d left want 3 and 0",
                     got, exp_q.size());
        end
    endtask

    task automatic test_bubble_collapse();
        logic acc, ox, ov;
        logic [63:0] od, e;
        logic [63:0] d[4];
        logic [5:0] s[4];
        int got, acc2;
        for (int i = 0; i < 4; i++) begin
            d[i] = {$urandom, $urandom};
            s[i] = 6'(i * 11 + 5);
        end
        tick(1'b1, d[0], s[0], 1'b1, 1'b0, acc, ox, ov, od);
        tests_run++;
        if (acc !== 1'b1) begin
            fails++;
            $display("FAIL bubble_first_accept: got %b want 1", acc);
        end
        exp_q.push_back(ref_shift(d[0], s[0], 1'b1));
        repeat (3) tick(1'b0, 64'h0, 6'd0, 1'b0, 1'b0, acc, ox, ov, od);
        tests_run++;
        if (ov !== 1'b1) begin
            fails++;
            $display("FAIL bubble_stage3_full: got out_valid %b want 1", ov);
        end
        acc2 = 0;
        for (int i = 1; i < 3; i++) begin
            tick(1'b1, d[i], s[i], 1'b1, 1'b0, acc, ox, ov, od);
            if (acc) begin
                acc2++;
                exp_q.push_back(ref_shift(d[i], s[i], 1'b1));
            end
        end
        tests_run++;
        if (acc2 !== 2) begin
            fails++;
            $display("FAIL bubble_accepts: got %0d want 2", acc2);
        end
        acc2 = 0;
        repeat (2) begin
            tick(1'b1, d[3], s[3], 1'b0, 1'b0, acc, ox, ov, od);
            if (acc) acc2++;
        end
        tests_run++;
        if (acc2 !== 0) begin
            fails++;
            $display("FAIL bubble_stall: got %0d accepts want 0", acc2);
        end
        got = 0;
        tick(1'b1, d[3], s[3], 1'b0, 1'b1, acc, ox, ov, od);
        tests_run++;
        if (acc !== 1'b1) begin
            fails++;
            $display("FAIL bubble_release_accept: got %b want 1", acc);
        end
        for (int c = 0; c < 10 && got < 4; c++) begin
            if (c > 0) tick(1'b0, 64'h0, 6'd0, 1'b0, 1'b1, acc, ox, ov, od);
            if (ox) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL bubble_unexpected: got %h with empty scoreboard", od);
                end else begin
                    e = exp_q.pop_front();
                    if (od !== e) begin
                        fails++;
                        $display("FAIL bubble_data_%0d: got %h want %h", got, od, e);
                    end
                end
                got++;
            end
            if (c == 0 && acc) exp_q.push_back(ref_shift(d[3], s[3], 1'b0));
        end
        tests_run++;
        if (got !== 4) begin
            fails++;
            $display("FAIL bubble_count: got %0d want 4", got);
        end
    endtask

    task automatic test_reset_mid();
        logic acc, ox, ov;
        logic [63:0] od, e;
        int accepts, stale, lat;
        accepts = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 64'hDEAD_BEEF_0000_0000 + 64'(i), 6'(i + 1), 1'b0, 1'b0,
                 acc, ox, ov, od);
            if (acc) accepts++;
        end
        tests_run++;
        if (accepts !== 3) begin
            fails++;
            $display("FAIL rst_mid_fill: got %0d accepts want 3", accepts);
        end
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_in_ready: got %b want 0", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        exp_q.delete();
        tests_run++;
        if (out_valid !== 1'b0 || shiftedData !== 64'h0) begin
            fails++;
            $display("FAIL rst_mid_flush: got valid %b data %h want 0 and 0",
                     out_valid, shiftedData);
        end
        stale = 0;
        repeat (4) begin
            tick(1'b0, 64'h0, 6'd0, 1'b0, 1'b1, acc, ox, ov, od);
            if (ov) stale++;
        end
        tests_run++;
        if (stale !== 0) begin
            fails++;
            $display("FAIL rst_mid_stale: got %0d valid cycles want 0", stale);
        end
        tick(1'b1, 64'h8000_0000_0000_00F0, 6'd4, 1'b1, 1'b1, acc, ox, ov, od);
        if (acc) exp_q.push_back(64'hF800_0000_0000_000F);
        lat = -1;
        for (int n = 1; n <= 8 && lat < 0; n++) begin
            tick(1'b0, 64'h0, 6'd0, 1'b0, 1'b1, acc, ox, ov, od);
            if (ox) begin
                lat = n;
                tests_run++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL rst_mid_new_op: got %h with empty scoreboard", od);
                end else begin
                    e = exp_q.pop_front();
                    if (od !== e) begin
                        fails++;
                        $display("FAIL rst_mid_new_op: got %h want %h", od, e);
                    end
                end
            end
        end
        tests_run++;
        if (lat !== 3) begin
            fails++;
            $display("FAIL rst_mid_latency: got %0d want 3 (-1 = timeout)", lat);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dataIn    = '0;
        shift     = '0;
        arith     = 1'b0;
        test_reset();
        test_single();
        test_sign_fill();
        test_stream();
        test_backpressure();
        test_bubble_collapse();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
